// File: rtl/gelu_stream_pkg.sv
// rtl/gelu_stream_pkg.sv - shared constants and state type for the GELU row streamer
package gelu_stream_pkg;

    localparam int DEF_GELU_NUM     = 128;
    localparam int DEF_DIMENTION    = 64;
    localparam int DEF_OUTPUT_WIDTH = 8;
    localparam int ROW_BITS         = DEF_OUTPUT_WIDTH * DEF_DIMENTION;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } stream_state_t;

endpackage

// File: rtl/gelu_row_select.sv
// rtl/gelu_row_select.sv - combinational row mux from the captured tile buffer
module gelu_row_select #(
    parameter int GELU_NUM  = 128,
    parameter int ROW_W     = 512,
    parameter int ROW_IDX_W = $clog2(GELU_NUM)
) (
    input  logic [ROW_W*GELU_NUM-1:0] tile,
    input  logic [ROW_IDX_W-1:0]      row_idx,
    output logic [ROW_W-1:0]          row
);

    always_comb begin
        row = '0;
        for (int i = 0; i < GELU_NUM; i++) begin
            if (row_idx == ROW_IDX_W'(i)) begin
                row = tile[i*ROW_W +: ROW_W];
            end
        end
    end

endmodule

// File: rtl/gelu_row_streamer.sv
// rtl/gelu_row_streamer.sv - captures a GELU tile and streams it out one row per handshake
module gelu_row_streamer
    import gelu_stream_pkg::*;
#(
    parameter int GELU_NUM     = DEF_GELU_NUM,
    parameter int DIMENTION    = DEF_DIMENTION,
    parameter int OUTPUT_WIDTH = DEF_OUTPUT_WIDTH,
    parameter int ROW_IDX_W    = $clog2(GELU_NUM)
) (
    input  logic                                       clk_p,
    input  logic                                       rst_p,
    input  logic [OUTPUT_WIDTH*GELU_NUM*DIMENTION-1:0] in_data,
    input  logic                                       in_valid_n,
    output logic                                       in_busy,
    output logic [OUTPUT_WIDTH*DIMENTION-1:0]          out_row,
    output logic [ROW_IDX_W-1:0]                       out_row_idx,
    output logic                                       out_last,
    output logic                                       out_valid_n,
    input  logic                                       out_ready_n,
    output logic                                       overrun
);

    localparam int ROW_W = OUTPUT_WIDTH * DIMENTION;

    stream_state_t                 state, next_state;
    logic [ROW_IDX_W-1:0]          row_cnt, next_row_cnt;
    logic                          prev_valid_n;
    logic [ROW_W*GELU_NUM-1:0]     buffer;
    logic [ROW_W-1:0]              sel_row;
    logic                          capture, transfer, last_row;
    logic                          load_tile, drop_tile;

    assign capture  = !in_valid_n && prev_valid_n;
    assign transfer = (state == STREAM) && !out_ready_n;
    assign last_row = (row_cnt == ROW_IDX_W'(GELU_NUM - 1));

    always_ff @(posedge clk_p or posedge rst_p) begin
        if (rst_p) begin
            state        <= IDLE;
            row_cnt      <= '0;
            prev_valid_n <= 1'b1;
            overrun      <= 1'b0;
        end else begin
            state        <= next_state;
            row_cnt      <= next_row_cnt;
            prev_valid_n <= in_valid_n;
            overrun      <= drop_tile;
        end
    end

    // Tile storage is deliberately left out of reset; it is only read while STREAM.
    always_ff @(posedge clk_p) begin
        if (load_tile) begin
            buffer <= in_data;
        end
    end

    always_comb begin
        next_state   = state;
        next_row_cnt = row_cnt;
        load_tile    = 1'b0;
        drop_tile    = 1'b0;
        case (state)
            IDLE: begin
                if (capture) begin
                    load_tile    = 1'b1;
                    next_row_cnt = '0;
                    next_state   = STREAM;
                end
            end
            STREAM: begin
                if (transfer && last_row) begin
                    next_row_cnt = '0;
                    // A new edge landing on the final handshake chains straight into the next tile.
                    if (capture) begin
                        load_tile = 1'b1;
                    end else begin
                        next_state = IDLE;
                    end
                end else begin
                    drop_tile = capture;
                    if (transfer) begin
                        next_row_cnt = row_cnt + ROW_IDX_W'(1);
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

    gelu_row_select #(
        .GELU_NUM  (GELU_NUM),
        .ROW_W     (ROW_W),
        .ROW_IDX_W (ROW_IDX_W)
    ) u_row_select (
        .tile    (buffer),
        .row_idx (row_cnt),
        .row     (sel_row)
    );

    assign in_busy     = (state == STREAM);
    assign out_valid_n = (state != STREAM);
    assign out_row     = (state == STREAM) ? sel_row : '0;
    assign out_row_idx = (state == STREAM) ? row_cnt : '0;
    assign out_last    = (state == STREAM) && last_row;

endmodule

// File: tb/tb_gelu_row_streamer.sv
// tb/tb_gelu_row_streamer.sv - scoreboard bench for gelu_row_streamer with a queue-based tile model
module tb_gelu_row_streamer;

    localparam int N   = 4;
    localparam int D   = 2;
    localparam int W   = 8;
    localparam int IW  = $clog2(N);
    localparam int RW  = W * D;
    localparam int TW  = RW * N;

    typedef struct {
        logic [RW-1:0] row;
        int            idx;
        logic          last;
    } exp_row_t;

    logic          clk_p = 1'b0;
    logic          rst_p = 1'b1;
    logic [TW-1:0] in_data = '0;
    logic          in_valid_n = 1'b1;
    logic          in_busy;
    logic [RW-1:0] out_row;
    logic [IW-1:0] out_row_idx;
    logic          out_last;
    logic          out_valid_n;
    logic          out_ready_n = 1'b1;
    logic          overrun;

    int checks = 0;
    int errors = 0;

    exp_row_t exp_q[$];
    int       rem = 0;
    logic     mprev = 1'b1;
    logic     exp_ovr = 1'b0;

    gelu_row_streamer #(
        .GELU_NUM     (N),
        .DIMENTION    (D),
        .OUTPUT_WIDTH (W)
    ) dut (
        .clk_p       (clk_p),
        .rst_p       (rst_p),
        .in_data     (in_data),
        .in_valid_n  (in_valid_n),
        .in_busy     (in_busy),
        .out_row     (out_row),
        .out_row_idx (out_row_idx),
        .out_last    (out_last),
        .out_valid_n (out_valid_n),
        .out_ready_n (out_ready_n),
        .overrun     (overrun)
    );

    always #5 clk_p = ~clk_p;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: one tile is a list of rows; the stream holds `rem` rows still to hand over.
    always @(negedge clk_p) begin
        if (rst_p) begin
            mprev = 1'b1;
        end else begin
            logic xfer, fin, cap;
            check("busy", in_busy, rem > 0);
            check("valid_n", out_valid_n, !(rem > 0));
            check("overrun", overrun, exp_ovr);
            xfer = (rem > 0) && !out_ready_n;
            fin  = xfer && (rem == 1);
            cap  = !in_valid_n && mprev;
            if (xfer) rem--;
            exp_ovr = 1'b0;
            if (cap) begin
                if (rem == 0) begin
                    for (int i = 0; i < N; i++) begin
                        exp_row_t e;
                        e.row  = in_data[i*RW +: RW];
                        e.idx  = i;
                        e.last = (i == N - 1);
                        exp_q.push_back(e);
                    end
                    rem = N;
                end else begin
                    exp_ovr = 1'b1;
                end
            end
            mprev = in_valid_n;
        end
    end

    logic          m_was_valid = 1'b0;
    logic          m_was_xfer  = 1'b0;
    logic [RW-1:0] m_row;
    logic [IW-1:0] m_idx;

    always @(negedge clk_p) begin
        if (rst_p) begin
            m_was_valid = 1'b0;
            m_was_xfer  = 1'b0;
        end else begin
            if (out_valid_n) begin
                check("idle_row", out_row, 0);
                check("idle_idx", out_row_idx, 0);
                check("idle_last", out_last, 0);
            end else begin
                if (m_was_valid && !m_was_xfer) begin
                    check("hold_row", out_row, m_row);
                    check("hold_idx", out_row_idx, m_idx);
                end
                if (!out_ready_n) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_row: got idx %0d row %0h expected no row at %0t",
                                 out_row_idx, out_row, $time);
                    end else begin
                        exp_row_t e;
                        e = exp_q.pop_front();
                        check("row", out_row, e.row);
                        check("row_idx", out_row_idx, e.idx);
                        check("last", out_last, e.last);
                    end
                end
            end
            m_was_valid = !out_valid_n;
            m_was_xfer  = !out_valid_n && !out_ready_n;
            m_row       = out_row;
            m_idx       = out_row_idx;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk_p);
        #1;
    endtask

    task automatic rand_tile();
        in_data = {$urandom, $urandom};
    endtask

    task automatic async_reset();
        rst_p = 1'b1;
        exp_q.delete();
        rem     = 0;
        exp_ovr = 1'b0;
        #1;
        check("rst_valid_n", out_valid_n, 1);
        check("rst_busy", in_busy, 0);
        check("rst_overrun", overrun, 0);
        check("rst_row", out_row, 0);
        check("rst_idx", out_row_idx, 0);
        check("rst_last", out_last, 0);
        @(posedge clk_p);
        #1;
        rst_p = 1'b0;
    endtask

    initial begin
        #3;
        async_reset();
        step(2);

        // single tile, level held low afterwards
        in_data     = {16'h0706, 16'h0504, 16'h0302, 16'h0100};
        in_valid_n  = 1'b0;
        out_ready_n = 1'b0;
        step(9);
        in_valid_n  = 1'b1;
        step(1);

        // back-pressure while idx=1
        rand_tile();
        in_data[RW +: RW] = 16'h0302;
        in_valid_n = 1'b0;
        step(2);
        check("bp_idx", out_row_idx, 1);
        out_ready_n = 1'b1;
        step(3);
        check("bp_hold_row", out_row, 16'h0302);
        out_ready_n = 1'b0;
        step(1);
        check("bp_next_idx", out_row_idx, 2);
        in_valid_n = 1'b1;
        step(4);

        // overrun: second falling edge while idx=2
        rand_tile();
        in_valid_n = 1'b0;
        step(1);
        in_valid_n = 1'b1;
        step(2);
        check("ovr_idx", out_row_idx, 2);
        rand_tile();
        in_valid_n = 1'b0;
        step(1);
        check("ovr_pulse", overrun, 1);
        step(1);
        check("ovr_clear", overrun, 0);
        step(3);
        in_valid_n = 1'b1;
        step(1);

        // back-to-back: edge on the row-3 transfer
        rand_tile();
        in_valid_n = 1'b0;
        step(1);
        in_valid_n = 1'b1;
        step(3);
        check("b2b_idx3", out_row_idx, 3);
        rand_tile();
        in_valid_n = 1'b0;
        step(1);
        check("b2b_idx0", out_row_idx, 0);
        check("b2b_valid_n", out_valid_n, 0);
        step(5);
        in_valid_n = 1'b1;
        step(1);

        // reset mid-stream at idx=2 with in_valid_n held low
        rand_tile();
        in_valid_n = 1'b0;
        step(3);
        check("rst_mid_idx", out_row_idx, 2);
        #2;
        async_reset();
        step(1);
        check("rst_recap_idx", out_row_idx, 0);
        step(5);

        // randomized traffic
        for (int c = 0; c < 600; c++) begin
            rand_tile();
            out_ready_n = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 4) == 0) in_valid_n = ~in_valid_n;
            step(1);
        end

        in_valid_n  = 1'b1;
        out_ready_n = 1'b0;
        step(N + 3);
        check("drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
